// File: rtl/axisv_frame_sched.sv
// Round-robin frame scheduler: grants one AXI4-Stream source per whole frame, triggers it,
// forwards its beats to the shared sink, then idles for a fixed gap. A watchdog aborts stalled sources.
module axisv_frame_sched #(
  parameter int N_SRC      = 2,
  parameter int DATA_WIDTH = 18,
  parameter int FRAME_GAP  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          aclk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [N_SRC-1:0]              src_mask_i,
  output logic [N_SRC-1:0]              src_trigger_o,
  input  logic [N_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_SRC-1:0]              s_axis_tvalid,
  output logic [N_SRC-1:0]              s_axis_tready,
  input  logic [N_SRC-1:0]              s_axis_tlast,
  input  logic [N_SRC-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [$clog2(N_SRC):0]        cur_src_o,
  output logic                          busy_o,
  output logic [15:0]                   frame_cnt_o,
  output logic                          timeout_o
);

  localparam int CW = $clog2(N_SRC) + 1;
  localparam int GW = $clog2(FRAME_GAP + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TRIG,
    STREAM,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cur_src_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [WW-1:0] wd_cnt, wd_nxt;
  logic [15:0]   frame_cnt_nxt;
  logic          timeout_nxt;
  logic          sel_found;
  logic [CW-1:0] sel_idx;
  logic          fire;
  logic          eof;

  // Stream handshake: m_axis_tvalid/s_axis_tvalid hold a beat until the matching ready is high;
  // a beat transfers on a rising clock edge where valid and ready are both 1. Only the granted
  // source is ever connected, and only while streaming.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (state == STREAM && cur_src_o == CW'(i)) begin
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid    = s_axis_tvalid[i];
        m_axis_tlast     = s_axis_tlast[i];
        m_axis_tuser     = s_axis_tuser[i];
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign fire   = m_axis_tvalid & m_axis_tready;
  assign eof    = fire & m_axis_tuser;
  assign busy_o = (state == TRIG) || (state == STREAM);

  // First eligible source strictly after the current one, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = cur_src_o;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!sel_found && src_mask_i[i] && ((int'(cur_src_o) + k) % N_SRC) == i) begin
          sel_found = 1'b1;
          sel_idx   = CW'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_src_nxt   = cur_src_o;
    gap_nxt       = gap_cnt;
    wd_nxt        = wd_cnt;
    frame_cnt_nxt = frame_cnt_o;
    timeout_nxt   = timeout_o;
    src_trigger_o = '0;
    case (state)
      IDLE: begin
        if (enable_i) state_nxt = SELECT;
      end
      SELECT: begin
        if (sel_found) begin
          cur_src_nxt = sel_idx;
          state_nxt   = TRIG;
        end
      end
      TRIG: begin
        for (int i = 0; i < N_SRC; i++) begin
          if (cur_src_o == CW'(i)) src_trigger_o[i] = 1'b1;
        end
        wd_nxt    = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (eof) begin
          frame_cnt_nxt = frame_cnt_o + 16'd1;
          gap_nxt       = '0;
          state_nxt     = GAP;
        end else if (fire) begin
          wd_nxt = '0;
        end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
          // TIMEOUT consecutive cycles without a transfer: abandon this frame.
          timeout_nxt = 1'b1;
          gap_nxt     = '0;
          state_nxt   = GAP;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(FRAME_GAP - 1)) begin
          state_nxt = enable_i ? SELECT : IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cur_src_o   <= CW'(N_SRC - 1);
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      frame_cnt_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_src_o   <= cur_src_nxt;
      gap_cnt     <= gap_nxt;
      wd_cnt      <= wd_nxt;
      frame_cnt_o <= frame_cnt_nxt;
      timeout_o   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_axisv_frame_sched.sv
// Bench for axisv_frame_sched: behavioural frame sources, a scoreboard of expected sink beats
// filled when a source is triggered, and one task per scenario.
module tb_axisv_frame_sched;

  localparam int N_SRC     = 2;
  localparam int DW        = 18;
  localparam int FRAME_GAP = 16;
  localparam int TIMEOUT   = 64;
  localparam int BEATS     = 32;
  localparam int CW        = $clog2(N_SRC) + 1;

  logic                  aclk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic [N_SRC-1:0]      src_mask = '0;
  logic [N_SRC-1:0]      src_trigger;
  logic [N_SRC*DW-1:0]   s_tdata = '0;
  logic [N_SRC-1:0]      s_tvalid = '0;
  logic [N_SRC-1:0]      s_tready;
  logic [N_SRC-1:0]      s_tlast = '0;
  logic [N_SRC-1:0]      s_tuser = '0;
  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid;
  logic                  m_tready = 1'b0;
  logic                  m_tlast;
  logic                  m_tuser;
  logic [CW-1:0]         cur_src;
  logic                  busy;
  logic [15:0]           frame_cnt;
  logic                  timeout;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [DW+1:0]   exp_q[$];
  int              trig_log[$];
  int              beat[N_SRC];
  int              frame_no[N_SRC];
  int              stall_at[N_SRC];
  bit              active[N_SRC];
  bit              pend[N_SRC];
  bit              rand_ready = 1'b0;
  int              frame_beats = 0;
  int              beat_total = 0;

  axisv_frame_sched #(
    .N_SRC(N_SRC), .DATA_WIDTH(DW), .FRAME_GAP(FRAME_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk_i(aclk), .rst_i(rst), .enable_i(enable), .src_mask_i(src_mask),
    .src_trigger_o(src_trigger),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cur_src_o(cur_src), .busy_o(busy), .frame_cnt_o(frame_cnt), .timeout_o(timeout)
  );

  always #5 aclk = ~aclk;

  // Beat b of frame fr from source src: {tuser, tlast, data}; 8 lines of 4 pixels.
  function automatic logic [DW+1:0] beat_word(int src, int fr, int b);
    logic [DW-1:0] d;
    d = DW'((src << 17) | ((fr % 32) << 12) | b);
    return {(b == BEATS - 1), (b % 4 == 3), d};
  endfunction

  // Sources, sink and scoreboard monitor, all working on the falling edge.
  always @(negedge aclk) begin : model
    logic [DW+1:0]    w;
    logic [N_SRC-1:0] oh;
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        active[i] = 1'b0;
        pend[i]   = 1'b0;
        beat[i]   = 0;
      end
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      m_tready = 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (pend[i]) begin
          beat[i]++;
          if (beat[i] == BEATS) active[i] = 1'b0;
        end
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (src_trigger[i]) begin
          active[i] = 1'b1;
          beat[i]   = 0;
          frame_no[i]++;
          trig_log.push_back(i);
          frame_beats = 0;
          for (int b = 0; b < BEATS && b < stall_at[i]; b++)
            exp_q.push_back(beat_word(i, frame_no[i], b));
        end
      end
      for (int i = 0; i < N_SRC; i++) begin
        w = beat_word(i, frame_no[i], beat[i]);
        s_tvalid[i]           = active[i] && (beat[i] < stall_at[i]);
        s_tdata[i*DW +: DW]   = w[DW-1:0];
        s_tlast[i]            = w[DW];
        s_tuser[i]            = w[DW+1];
      end
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      oh = N_SRC'(1) << cur_src;
      n_cmp++;
      if (((s_tready & ~oh) != '0) || (!busy && (m_tvalid || s_tready != '0))) begin
        n_bad++;
        $display("FAIL ready_gating got tready=%b m_valid=%b busy=%b cur=%0d", s_tready, m_tvalid, busy, cur_src);
      end
      if (src_trigger != '0) begin
        n_cmp++;
        if (src_trigger !== oh || !busy) begin
          n_bad++;
          $display("FAIL trigger_onehot got %b exp %b", src_trigger, oh);
        end
      end
      for (int i = 0; i < N_SRC; i++) pend[i] = s_tvalid[i] && s_tready[i];
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_unexpected got %h", {m_tuser, m_tlast, m_tdata});
        end else begin
          w = exp_q.pop_front();
          if ({m_tuser, m_tlast, m_tdata} !== w) begin
            n_bad++;
            $display("FAIL beat_data got %h exp %h", {m_tuser, m_tlast, m_tdata}, w);
          end
        end
        frame_beats++;
        beat_total++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic wait_trig(int n, int budget);
    int c = 0;
    while (trig_log.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    n_cmp++;
    if (trig_log.size() < n) begin
      n_bad++;
      $display("FAIL wait_trig got %0d triggers exp %0d", trig_log.size(), n);
    end
  endtask

  task automatic wait_beats(int n, int budget);
    int c = 0;
    while (frame_beats < n && c < budget) begin
      tick(1);
      c++;
    end
    n_cmp++;
    if (frame_beats < n) begin
      n_bad++;
      $display("FAIL wait_beats got %0d exp %0d", frame_beats, n);
    end
  endtask

  task automatic wait_busy_low(int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL wait_busy_low got busy=%b exp 0", busy);
    end
  endtask

  task automatic wait_idle(int budget);
    wait_busy_low(budget);
    tick(FRAME_GAP + 4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    src_mask = '0;
    tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b exp 0", m_tvalid); end
    n_cmp++; if ({m_tuser, m_tlast, m_tdata} !== '0) begin n_bad++; $display("FAIL rst_m_data got %h exp 0", {m_tuser, m_tlast, m_tdata}); end
    n_cmp++; if (s_tready !== '0) begin n_bad++; $display("FAIL rst_s_ready got %b exp 0", s_tready); end
    n_cmp++; if (src_trigger !== '0) begin n_bad++; $display("FAIL rst_trigger got %b exp 0", src_trigger); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got %b exp 0", timeout); end
    n_cmp++; if (cur_src !== CW'(N_SRC - 1)) begin n_bad++; $display("FAIL rst_cur_src got %0d exp %0d", cur_src, N_SRC - 1); end
    rst = 1'b0;
    tick(5);
    n_cmp++; if (busy !== 1'b0 || trig_log.size() != 0) begin n_bad++; $display("FAIL idle_disabled got busy=%b trig=%0d exp 0 0", busy, trig_log.size()); end
  endtask

  task automatic test_round_robin;
    int exp_g[4];
    int c;
    exp_g = '{0, 1, 0, 1};
    trig_log.delete();
    beat_total = 0;
    src_mask = 2'b11;
    enable = 1'b1;
    wait_trig(1, 50);
    wait_busy_low(200);
    c = 0;
    while (!busy && c < 100) begin
      c++;
      tick(1);
    end
    n_cmp++; if (c != FRAME_GAP + 1) begin n_bad++; $display("FAIL gap_length got %0d exp %0d", c, FRAME_GAP + 1); end
    wait_trig(4, 400);
    enable = 1'b0;
    wait_idle(200);
    n_cmp++; if (trig_log.size() != 4) begin n_bad++; $display("FAIL rr_trigger_count got %0d exp 4", trig_log.size()); end
    for (int k = 0; k < 4 && k < trig_log.size(); k++) begin
      n_cmp++; if (trig_log[k] != exp_g[k]) begin n_bad++; $display("FAIL rr_grant%0d got %0d exp %0d", k, trig_log[k], exp_g[k]); end
    end
    n_cmp++; if (frame_cnt !== 16'd4) begin n_bad++; $display("FAIL rr_frame_cnt got %0d exp 4", frame_cnt); end
    n_cmp++; if (beat_total != 4 * BEATS) begin n_bad++; $display("FAIL rr_beats got %0d exp %0d", beat_total, 4 * BEATS); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_leftover got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_mask;
    trig_log.delete();
    src_mask = 2'b10;
    enable = 1'b1;
    wait_trig(2, 300);
    enable = 1'b0;
    wait_idle(200);
    n_cmp++; if (trig_log.size() != 2 || trig_log[0] != 1 || trig_log[1] != 1) begin n_bad++; $display("FAIL mask_src1 got n=%0d exp 2 grants of source 1", trig_log.size()); end
    n_cmp++; if (frame_cnt !== 16'd6) begin n_bad++; $display("FAIL mask_frame_cnt got %0d exp 6", frame_cnt); end
    trig_log.delete();
    src_mask = 2'b00;
    enable = 1'b1;
    tick(100);
    n_cmp++; if (trig_log.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL mask_zero got trig=%0d busy=%b exp 0 0", trig_log.size(), busy); end
    src_mask = 2'b01;
    tick(1);
    n_cmp++; if (src_trigger !== 2'b01) begin n_bad++; $display("FAIL mask_regrant_trig got %b exp 01", src_trigger); end
    n_cmp++; if (cur_src !== CW'(0)) begin n_bad++; $display("FAIL mask_regrant_cur got %0d exp 0", cur_src); end
    enable = 1'b0;
    wait_idle(200);
    n_cmp++; if (frame_cnt !== 16'd7) begin n_bad++; $display("FAIL mask_frame_cnt2 got %0d exp 7", frame_cnt); end
  endtask

  task automatic test_random_ready;
    int exp_g[4];
    exp_g = '{1, 0, 1, 0};
    trig_log.delete();
    beat_total = 0;
    rand_ready = 1'b1;
    src_mask = 2'b11;
    enable = 1'b1;
    wait_trig(4, 1500);
    enable = 1'b0;
    wait_idle(1000);
    rand_ready = 1'b0;
    n_cmp++; if (trig_log.size() != 4) begin n_bad++; $display("FAIL rand_trigger_count got %0d exp 4", trig_log.size()); end
    for (int k = 0; k < 4 && k < trig_log.size(); k++) begin
      n_cmp++; if (trig_log[k] != exp_g[k]) begin n_bad++; $display("FAIL rand_grant%0d got %0d exp %0d", k, trig_log[k], exp_g[k]); end
    end
    n_cmp++; if (beat_total != 4 * BEATS) begin n_bad++; $display("FAIL rand_beats got %0d exp %0d", beat_total, 4 * BEATS); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); end
    n_cmp++; if (frame_cnt !== 16'd11) begin n_bad++; $display("FAIL rand_frame_cnt got %0d exp 11", frame_cnt); end
  endtask

  task automatic test_enable_drop;
    logic [15:0] fc;
    fc = frame_cnt;
    trig_log.delete();
    src_mask = 2'b11;
    enable = 1'b1;
    wait_trig(1, 50);
    wait_beats(10, 100);
    enable = 1'b0;
    wait_busy_low(200);
    n_cmp++; if (frame_beats != BEATS) begin n_bad++; $display("FAIL drop_frame_len got %0d exp %0d", frame_beats, BEATS); end
    tick(FRAME_GAP + 100);
    n_cmp++; if (trig_log.size() != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL drop_no_retrigger got trig=%0d busy=%b exp 1 0", trig_log.size(), busy); end
    n_cmp++; if (frame_cnt !== fc + 16'd1) begin n_bad++; $display("FAIL drop_frame_cnt got %0d exp %0d", frame_cnt, fc + 16'd1); end
  endtask

  task automatic test_timeout;
    logic [15:0] fc;
    int c;
    fc = frame_cnt;
    stall_at[1] = 5;
    trig_log.delete();
    src_mask = 2'b10;
    enable = 1'b1;
    wait_trig(1, 50);
    src_mask = 2'b11;
    n_cmp++; if (trig_log.size() < 1 || trig_log[0] != 1) begin n_bad++; $display("FAIL to_grant got n=%0d exp grant of source 1", trig_log.size()); end
    wait_beats(5, 100);
    c = 0;
    while (busy && c < 200) begin
      c++;
      tick(1);
    end
    n_cmp++; if (c != TIMEOUT) begin n_bad++; $display("FAIL to_latency got %0d exp %0d", c, TIMEOUT); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got %b exp 1", timeout); end
    n_cmp++; if (frame_cnt !== fc) begin n_bad++; $display("FAIL to_frame_cnt got %0d exp %0d", frame_cnt, fc); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL to_leftover got %0d exp 0", exp_q.size()); end
    stall_at[1] = BEATS;
    wait_trig(2, 100);
    n_cmp++; if (trig_log.size() < 2 || trig_log[1] != 0) begin n_bad++; $display("FAIL to_next_grant got n=%0d exp grant of source 0", trig_log.size()); end
    enable = 1'b0;
    wait_idle(200);
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b exp 1", timeout); end
    n_cmp++; if (frame_cnt !== fc + 16'd1) begin n_bad++; $display("FAIL to_frame_cnt2 got %0d exp %0d", frame_cnt, fc + 16'd1); end
  endtask

  task automatic test_reset_mid;
    trig_log.delete();
    src_mask = 2'b11;
    enable = 1'b1;
    wait_trig(1, 50);
    wait_beats(20, 100);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (m_tvalid !== 1'b0 || s_tready !== '0) begin n_bad++; $display("FAIL midrst_stream got valid=%b ready=%b exp 0 0", m_tvalid, s_tready); end
    n_cmp++; if (busy !== 1'b0 || src_trigger !== '0 || m_tdata !== '0) begin n_bad++; $display("FAIL midrst_outputs got busy=%b trig=%b data=%h exp 0", busy, src_trigger, m_tdata); end
    n_cmp++; if (cur_src !== CW'(N_SRC - 1)) begin n_bad++; $display("FAIL midrst_cur got %0d exp %0d", cur_src, N_SRC - 1); end
    n_cmp++; if (frame_cnt !== 16'd0 || timeout !== 1'b0) begin n_bad++; $display("FAIL midrst_status got cnt=%0d to=%b exp 0 0", frame_cnt, timeout); end
    tick(2);
    exp_q.delete();
    trig_log.delete();
    rst = 1'b0;
    wait_trig(1, 50);
    n_cmp++; if (trig_log.size() < 1 || trig_log[0] != 0) begin n_bad++; $display("FAIL midrst_first_grant got n=%0d exp grant of source 0", trig_log.size()); end
    enable = 1'b0;
    wait_idle(200);
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_frame_cnt got %0d exp 1", frame_cnt); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL midrst_leftover got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < N_SRC; i++) begin
      stall_at[i] = BEATS;
      frame_no[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_mask();
    test_random_ready();
    test_enable_drop();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL global_time_limit got no end of run exp finish before 1ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
